// File: rtl/counter_seq_pkg.sv
// -----------------------------------------------------------------------------
// counter_seq_pkg
// Shared types for the counter run controller.
//   seq_state_e : controller state encoding (IDLE=0 .. DONE=4)
//   seq_mode_e  : run mode as latched at start
//   decode_mode : maps the raw 2-bit mode input onto a run mode
// -----------------------------------------------------------------------------
package counter_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CLEAR    = 3'd1,
    ST_RUN_UP   = 3'd2,
    ST_RUN_DOWN = 3'd3,
    ST_DONE     = 3'd4
  } seq_state_e;

  typedef enum logic [1:0] {
    MODE_ONESHOT  = 2'b00,
    MODE_PERIODIC = 2'b01,
    MODE_BOUNCE   = 2'b10
  } seq_mode_e;

  // Raw encoding 11 is reserved and behaves as ONESHOT. A counter with a
  // modulus below 3 has its top and bottom flags on the same count, so a
  // triangle run cannot turn around; such builds run BOUNCE as PERIODIC.
  function automatic seq_mode_e decode_mode(input logic [1:0] raw,
                                            input logic       bounce_ok);
    seq_mode_e m;
    case (raw)
      2'b01:   m = MODE_PERIODIC;
      2'b10:   m = bounce_ok ? MODE_BOUNCE : MODE_PERIODIC;
      default: m = MODE_ONESHOT;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/seq_lap_counter.sv
// -----------------------------------------------------------------------------
// seq_lap_counter
// Lap bookkeeping for the run controller.
//   clk, reset    : clock and synchronous active-high reset
//   clear_i       : zero the lap count (new run); wins over inc_i
//   inc_i         : one lap completed this cycle
//   laps_i        : latched lap target, 0 = unlimited
//   lap_count_o   : completed laps
//   final_lap_o   : the lap completing now (if inc_i) reaches the target
// -----------------------------------------------------------------------------
module seq_lap_counter
  import counter_seq_pkg::*;
#(
  parameter int LAPS_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              inc_i,
  input  logic [LAPS_W-1:0] laps_i,
  output logic [LAPS_W-1:0] lap_count_o,
  output logic              final_lap_o
);

  logic [LAPS_W-1:0] lap_q;
  logic [LAPS_W-1:0] lap_d;
  logic [LAPS_W-1:0] lap_plus1;
  logic              unlimited;
  logic              saturated;

  assign lap_plus1 = lap_q + 1'b1;
  assign unlimited = (laps_i == '0);
  assign saturated = &lap_q;

  // With a non-zero target the run ends on the matching lap, so the count
  // can never pass the target; only unlimited runs need saturation.
  assign final_lap_o = !unlimited && (lap_plus1 == laps_i);

  always_comb begin
    lap_d = lap_q;
    if (clear_i) begin
      lap_d = '0;
    end else if (inc_i && !(unlimited && saturated)) begin
      lap_d = lap_plus1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lap_q <= '0;
    end else begin
      lap_q <= lap_d;
    end
  end

  assign lap_count_o = lap_q;

endmodule

// File: rtl/counter_sequencer.sv
// -----------------------------------------------------------------------------
// counter_sequencer
// Run controller for an external modulo up/down counter with synchronous
// clear. Provides ONESHOT, PERIODIC and BOUNCE runs with lap counting,
// pause, stop and a one-cycle done pulse.
//
// Parameters
//   MODULO  : modulus of the controlled counter (only affects BOUNCE support)
//   LAPS_W  : width of the lap target and lap counter
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   start, stop, pause    : run request (IDLE only), abort, freeze
//   mode, laps            : run mode and lap target (0 = unlimited)
//   tc_top, tc_bottom     : counter flags, count==MODULO-1 / count==1
//   cnt_enable            : counter enable (Mealy)
//   cnt_up_down           : counter direction, 1 = up (Mealy)
//   cnt_clear_n           : active-low synchronous clear to the counter
//   busy, done, lap_count : status
//
// Build option
//   SEQ_AUTO_RESTART_EN : when defined, DONE with start high (and stop low)
//   goes straight to CLEAR, re-latching the configuration; done still pulses.
// -----------------------------------------------------------------------------
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int MODULO = 32,
  parameter int LAPS_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic [1:0]        mode,
  input  logic [LAPS_W-1:0] laps,
  input  logic              tc_top,
  input  logic              tc_bottom,
  output logic              cnt_enable,
  output logic              cnt_up_down,
  output logic              cnt_clear_n,
  output logic              busy,
  output logic              done,
  output logic [LAPS_W-1:0] lap_count
);

  localparam logic BOUNCE_OK = (MODULO >= 3);

  seq_state_e        state_q;
  seq_mode_e         mode_q;
  logic [LAPS_W-1:0] laps_q;
  logic              done_q;

  logic start_ok;
  logic ev_top;
  logic ev_bottom;
  logic final_lap;
  logic lap_inc;
  logic lap_clr;
  logic en_c;
  logic up_c;

  // Terminal flags only count as events while the counter is allowed to move.
  assign start_ok  = start && !stop;
  assign ev_top    = tc_top && !pause;
  assign ev_bottom = tc_bottom && !pause;

  // ---------------------------------------------------------------------------
  // Mealy decode: counter controls and lap events for the current cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    en_c    = 1'b0;
    up_c    = 1'b1;
    lap_inc = 1'b0;
    lap_clr = 1'b0;

    case (state_q)
      ST_IDLE: begin
        lap_clr = start_ok;
      end

      ST_RUN_UP: begin
        en_c = !pause;
        if (ev_top) begin
          case (mode_q)
            MODE_PERIODIC: begin
              // Non-final laps let the counter wrap to 0; the final one
              // leaves it parked on MODULO-1.
              lap_inc = 1'b1;
              en_c    = !final_lap;
            end
            MODE_BOUNCE: begin
              // Turn around on the top count itself so the next value is
              // MODULO-2 rather than a wrap to 0.
              up_c = 1'b0;
            end
            default: begin
              en_c = 1'b0;
            end
          endcase
        end
      end

      ST_RUN_DOWN: begin
        up_c = 1'b0;
        en_c = !pause;
        // Stepping 1 -> 0 completes the lap; the counter ends a BOUNCE on 0.
        lap_inc = ev_bottom;
      end

      ST_DONE: begin
`ifdef SEQ_AUTO_RESTART_EN
        lap_clr = start_ok;
`endif
      end

      default: begin
      end
    endcase

    // Abort: freeze the counter where it is and keep the lap count.
    if (stop && state_q != ST_IDLE) begin
      en_c    = 1'b0;
      lap_inc = 1'b0;
    end

    if (reset) begin
      en_c    = 1'b0;
      lap_inc = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // State register, latched configuration and registered done.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_ONESHOT;
      laps_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_ok) begin
            state_q <= ST_CLEAR;
            mode_q  <= decode_mode(mode, BOUNCE_OK);
            laps_q  <= laps;
          end
        end

        ST_CLEAR: begin
          state_q <= stop ? ST_IDLE : ST_RUN_UP;
        end

        ST_RUN_UP: begin
          if (stop) begin
            state_q <= ST_IDLE;
          end else if (ev_top) begin
            case (mode_q)
              MODE_PERIODIC: begin
                if (final_lap) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                end
              end
              MODE_BOUNCE: begin
                state_q <= ST_RUN_DOWN;
              end
              default: begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end
            endcase
          end
        end

        ST_RUN_DOWN: begin
          if (stop) begin
            state_q <= ST_IDLE;
          end else if (ev_bottom) begin
            if (final_lap) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_RUN_UP;
            end
          end
        end

        ST_DONE: begin
`ifdef SEQ_AUTO_RESTART_EN
          if (start_ok) begin
            state_q <= ST_CLEAR;
            mode_q  <= decode_mode(mode, BOUNCE_OK);
            laps_q  <= laps;
          end else begin
            state_q <= ST_IDLE;
          end
`else
          state_q <= ST_IDLE;
`endif
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  seq_lap_counter #(
    .LAPS_W (LAPS_W)
  ) u_laps (
    .clk         (clk),
    .reset       (reset),
    .clear_i     (lap_clr),
    .inc_i       (lap_inc),
    .laps_i      (laps_q),
    .lap_count_o (lap_count),
    .final_lap_o (final_lap)
  );

  assign cnt_enable  = en_c;
  assign cnt_up_down = up_c;
  // Reset also clears the counter so both sides leave reset together.
  assign cnt_clear_n = !reset && (state_q != ST_CLEAR);
  assign busy        = (state_q != ST_IDLE);
  assign done        = done_q;

endmodule

// File: tb/tb_counter_sequencer.sv
module tb_counter_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] laps = 8'd0;
  logic       tc_top;
  logic       tc_bottom;
  logic       cnt_enable;
  logic       cnt_up_down;
  logic       cnt_clear_n;
  logic       busy;
  logic       done;
  logic [7:0] lap_count;

  int n_checks = 0;
  int n_errors = 0;

  counter_sequencer #(
    .MODULO (8),
    .LAPS_W (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .mode        (mode),
    .laps        (laps),
    .tc_top      (tc_top),
    .tc_bottom   (tc_bottom),
    .cnt_enable  (cnt_enable),
    .cnt_up_down (cnt_up_down),
    .cnt_clear_n (cnt_clear_n),
    .busy        (busy),
    .done        (done),
    .lap_count   (lap_count)
  );

  always #5 clk = ~clk;

  // Plant: modulo-8 up/down counter with synchronous clear.
  logic [2:0] cnt_q = 3'd0;
  logic       rec = 1'b0;
  logic [2:0] obs_q[$];
  int         run_cycles = 0;

  assign tc_top    = (cnt_q == 3'd7);
  assign tc_bottom = (cnt_q == 3'd1);

  function automatic logic [2:0] plant_next(input logic [2:0] c, input logic up);
    return up ? c + 3'd1 : c - 3'd1;
  endfunction

  always @(posedge clk) begin
    if (!cnt_clear_n) begin
      cnt_q <= 3'd0;
    end else if (cnt_enable) begin
      cnt_q <= plant_next(cnt_q, cnt_up_down);
      if (rec) obs_q.push_back(plant_next(cnt_q, cnt_up_down));
    end
    if (busy && cnt_clear_n && !done && !pause) run_cycles <= run_cycles + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: the sequence of counter values a complete run visits, and
  // the number of unpaused running cycles it takes.
  task automatic build_expect(input logic [1:0] m, input int l,
                              output int exp_vals[$], output int exp_cyc,
                              output int exp_end, output int exp_laps);
    exp_vals.delete();
    if (m == 2'b01) begin
      for (int lap = 0; lap < l; lap++) begin
        for (int v = 1; v <= 7; v++) exp_vals.push_back(v);
        if (lap < l - 1) exp_vals.push_back(0);
      end
      exp_cyc = 8 * l; exp_end = 7; exp_laps = l;
    end else if (m == 2'b10) begin
      for (int lap = 0; lap < l; lap++) begin
        for (int v = 1; v <= 7; v++) exp_vals.push_back(v);
        for (int v = 6; v >= 0; v--) exp_vals.push_back(v);
      end
      exp_cyc = 14 * l; exp_end = 0; exp_laps = l;
    end else begin
      for (int v = 1; v <= 7; v++) exp_vals.push_back(v);
      exp_cyc = 8; exp_end = 7; exp_laps = 0;
    end
  endtask

  task automatic do_run(input string name, input logic [1:0] m, input int l,
                        input int pause_pct, input bit hold_at_top);
    int  exp_vals[$];
    int  exp_cyc, exp_end, exp_laps, first_bad;
    bit  got_done, held;
    int  lap_before;
    build_expect(m, l, exp_vals, exp_cyc, exp_end, exp_laps);
    obs_q.delete();
    rec = 1'b1;
    held = 1'b0;
    got_done = 1'b0;
    mode = m; laps = 8'(l); start = 1'b1;
    step();
    start = 1'b0;
    run_cycles = 0;
    n_checks++;
    if (cnt_clear_n !== 1'b0 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL %s_clear: clear_n=%b busy=%b required 0/1", name, cnt_clear_n, busy);
    end
    for (int c = 0; c < 800; c++) begin
      if (hold_at_top && !held && cnt_q == 3'd7 && busy && cnt_clear_n) begin
        held = 1'b1;
        lap_before = lap_count;
        pause = 1'b1;
        for (int k = 0; k < 5; k++) begin
          #1;
          n_checks++;
          if (cnt_enable !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_pause_en: enable=%b required 0", name, cnt_enable);
          end
          step();
          n_checks++;
          if (cnt_q !== 3'd7 || lap_count !== 8'(lap_before) || done !== 1'b0) begin
            n_errors++;
            $display("FAIL %s_pause_hold: count=%0d laps=%0d done=%b required 7/%0d/0",
                     name, cnt_q, lap_count, done, lap_before);
          end
        end
        pause = 1'b0;
      end
      pause = ($urandom_range(99) < pause_pct);
`ifndef SEQ_AUTO_RESTART_EN
      start = ($urandom_range(9) == 0);  // must be ignored while busy
`endif
      step();
      if (done) begin
        got_done = 1'b1;
        break;
      end
    end
    pause = 1'b0;
    start = 1'b0;
    n_checks++;
    if (!got_done) begin
      n_errors++;
      $display("FAIL %s_timeout: no done within budget", name);
      stop = 1'b1; step(); stop = 1'b0;
    end else begin
      n_checks++;
      if (int'(cnt_q) != exp_end || int'(lap_count) != exp_laps) begin
        n_errors++;
        $display("FAIL %s_end: count=%0d laps=%0d required %0d/%0d",
                 name, cnt_q, lap_count, exp_end, exp_laps);
      end
      step();
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0 || int'(lap_count) != exp_laps) begin
        n_errors++;
        $display("FAIL %s_idle: busy=%b done=%b laps=%0d required 0/0/%0d",
                 name, busy, done, lap_count, exp_laps);
      end
    end
    rec = 1'b0;
    n_checks++;
    if (run_cycles != exp_cyc) begin
      n_errors++;
      $display("FAIL %s_cycles: unpaused run cycles=%0d required %0d", name, run_cycles, exp_cyc);
    end
    first_bad = -1;
    if (obs_q.size() == exp_vals.size()) begin
      for (int i = 0; i < exp_vals.size(); i++)
        if (first_bad < 0 && int'(obs_q[i]) != exp_vals[i]) first_bad = i;
    end
    n_checks++;
    if (obs_q.size() != exp_vals.size() || first_bad >= 0) begin
      n_errors++;
      $display("FAIL %s_trace: %0d steps (first bad index %0d) required %0d steps",
               name, obs_q.size(), first_bad, exp_vals.size());
    end
    $display("run %s mode=%0d laps=%0d steps=%0d lap_count=%0d", name, m, l, obs_q.size(), lap_count);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || lap_count !== 8'd0 ||
        cnt_clear_n !== 1'b0 || cnt_enable !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: busy=%b done=%b laps=%0d clear_n=%b en=%b required 0/0/0/0/0",
               busy, done, lap_count, cnt_clear_n, cnt_enable);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (cnt_clear_n !== 1'b1 || cnt_up_down !== 1'b1 || cnt_enable !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_idle: clear_n=%b up=%b en=%b required 1/1/0",
               cnt_clear_n, cnt_up_down, cnt_enable);
    end
    $display("reset done count=%0d", cnt_q);
  endtask

  task automatic test_modes();
    do_run("oneshot", 2'b00, 0, 0, 1'b0);
    do_run("oneshot_rsvd", 2'b11, 5, 25, 1'b0);
    do_run("periodic3", 2'b01, 3, 20, 1'b0);
    do_run("bounce2", 2'b10, 2, 20, 1'b0);
    do_run("periodic_rand", 2'b01, int'($urandom_range(1, 4)), 30, 1'b0);
    do_run("bounce_rand", 2'b10, int'($urandom_range(1, 3)), 30, 1'b0);
  endtask

  task automatic test_pause();
    do_run("pause_top", 2'b01, 2, 0, 1'b1);
  endtask

  task automatic test_stop();
    bit found = 1'b0;
    bit saw_done = 1'b0;
    mode = 2'b01; laps = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      step();
      if (done) saw_done = 1'b1;
      if (lap_count == 8'd1 && cnt_q == 3'd4) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL stop_reach: count 4 in lap 1 not reached");
    end
    stop = 1'b1;
    #1;
    n_checks++;
    if (cnt_enable !== 1'b0) begin
      n_errors++;
      $display("FAIL stop_en: enable=%b required 0", cnt_enable);
    end
    step();
    stop = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (done) saw_done = 1'b1;
      step();
    end
    n_checks++;
    if (busy !== 1'b0 || cnt_q !== 3'd4 || lap_count !== 8'd1 || saw_done) begin
      n_errors++;
      $display("FAIL stop_hold: busy=%b count=%0d laps=%0d done_seen=%b required 0/4/1/0",
               busy, cnt_q, lap_count, saw_done);
    end
    start = 1'b1; stop = 1'b1;
    step();
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL stop_beats_start: busy=%b required 0", busy);
    end
    stop = 1'b0;
    step();
    start = 1'b0;
    n_checks++;
    if (cnt_clear_n !== 1'b0 || lap_count !== 8'd0) begin
      n_errors++;
      $display("FAIL stop_restart: clear_n=%b laps=%0d required 0/0", cnt_clear_n, lap_count);
    end
    step();
    n_checks++;
    if (cnt_q !== 3'd0) begin
      n_errors++;
      $display("FAIL stop_recleared: count=%0d required 0", cnt_q);
    end
    stop = 1'b1; step(); stop = 1'b0;
    $display("stop done count=%0d busy=%b", cnt_q, busy);
  endtask

  task automatic test_saturation();
    mode = 2'b01; laps = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 260 * 8; c++) step();
    n_checks++;
    if (lap_count !== 8'hFF || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL saturate: laps=%0d busy=%b required 255/1", lap_count, busy);
    end
    stop = 1'b1; step(); stop = 1'b0;
    $display("saturation lap_count=%0d", lap_count);
  endtask

  task automatic test_reset_mid_bounce();
    bit found = 1'b0;
    mode = 2'b10; laps = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 0; c < 200; c++) begin
      step();
      if (lap_count >= 8'd1 && cnt_up_down === 1'b0 && cnt_q != 3'd0) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL rst_mid_reach: down leg of lap 2 not reached");
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (cnt_clear_n !== 1'b0 || cnt_enable !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_mid_comb: clear_n=%b en=%b required 0/0", cnt_clear_n, cnt_enable);
    end
    step();
    reset = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || lap_count !== 8'd0 || done !== 1'b0 || cnt_q !== 3'd0) begin
      n_errors++;
      $display("FAIL rst_mid_state: busy=%b laps=%0d done=%b count=%0d required 0/0/0/0",
               busy, lap_count, done, cnt_q);
    end
    $display("reset_mid_bounce busy=%b", busy);
  endtask

  task automatic test_back_to_back();
    bit got = 1'b0;
    mode = 2'b00; laps = 8'd0; start = 1'b1;
    step();
    for (int c = 0; c < 50; c++) begin
      step();
      if (done) begin got = 1'b1; break; end
    end
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL b2b_first_done: no done within budget");
    end
    step();
`ifdef SEQ_AUTO_RESTART_EN
    n_checks++;
    if (busy !== 1'b1 || cnt_clear_n !== 1'b0 || lap_count !== 8'd0) begin
      n_errors++;
      $display("FAIL b2b_restart: busy=%b clear_n=%b laps=%0d required 1/0/0",
               busy, cnt_clear_n, lap_count);
    end
`else
    n_checks++;
    if (busy !== 1'b0 || cnt_clear_n !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_idle: busy=%b clear_n=%b required 0/1", busy, cnt_clear_n);
    end
    step();
    n_checks++;
    if (cnt_clear_n !== 1'b0) begin
      n_errors++;
      $display("FAIL b2b_restart: clear_n=%b required 0", cnt_clear_n);
    end
`endif
    start = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 50; c++) begin
      step();
      if (done) begin got = 1'b1; break; end
    end
    step();
    n_checks++;
    if (!got || busy !== 1'b0 || cnt_q !== 3'd7) begin
      n_errors++;
      $display("FAIL b2b_second: done_seen=%b busy=%b count=%0d required 1/0/7", got, busy, cnt_q);
    end
    $display("back_to_back count=%0d busy=%b", cnt_q, busy);
  endtask

  initial begin
    test_reset();
    test_modes();
    test_pause();
    test_stop();
    test_saturation();
    test_reset_mid_bounce();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
